prefix_adder_seq: RTL

Iterative, area-reduced Kogge-Stone adder. Instead of instantiating all log2(WIDTH) prefix rows, it owns a single row of WIDTH `prefix_node` cells and sequences it over log2(WIDTH) clock cycles, feeding each level's generate/propagate vector back into the row with a doubling span. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the reference sequential user of the `prefix_node` datapath cell.

---
 rtl/prefix_adder_pkg.sv | 21 ++
 rtl/prefix_node.sv | 15 +
 rtl/prefix_row.sv | 45 ++++
 rtl/prefix_adder_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared types and sizing helpers for the sequential prefix adder.
// Optional carry-in is enabled with PREFIX_ADDER_SEQ_CIN_EN.
package prefix_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  function automatic int levels_of(input int w);
    return $clog2(w);
  endfunction

  function automatic int level_w(input int w);
    int l;
    l = $clog2($clog2(w));
    return (l < 1) ? 1 : l;
  endfunction

endpackage

// File: rtl/prefix_node.sv
// Kogge-Stone prefix cell: combines a high and a low
// generate/propagate pair into one.
module prefix_node (
  input  logic gen_high,
  input  logic prop_high,
  input  logic gen_low,
  input  logic prop_low,
  output logic gen_out,
  output logic prop_out
);

  assign gen_out  = gen_high | (prop_high & gen_low);
  assign prop_out = prop_high & prop_low;

endmodule

// File: rtl/prefix_row.sv
// One row of prefix nodes with a runtime span of 2^level;
// bits below the span pass through unchanged.
module prefix_row #(
  parameter int WIDTH = 8,
  parameter int LW    = 2
) (
  input  logic [LW-1:0]    level,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  localparam int SW = $clog2(WIDTH) + 1;

  logic [SW-1:0]    span;
  logic [WIDTH-1:0] g_low;
  logic [WIDTH-1:0] p_low;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] g_node;
  logic [WIDTH-1:0] p_node;

  // Shifting by the span lines up G/P[i-s] with bit i.
  always_comb begin
    span  = SW'(1) << level;
    g_low = g_in << span;
    p_low = p_in << span;
    hi    = {WIDTH{1'b1}} << span;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_node_col
    prefix_node u_node (
      .gen_high (g_in[i]),
      .prop_high(p_in[i]),
      .gen_low  (g_low[i]),
      .prop_low (p_low[i]),
      .gen_out  (g_node[i]),
      .prop_out (p_node[i])
    );
  end

  assign g_out = (g_node & hi) | (g_in & ~hi);
  assign p_out = (p_node & hi) | (p_in & ~hi);

endmodule

// File: rtl/prefix_adder_seq.sv
// Iterative Kogge-Stone adder reusing one prefix row per level.
// Carry-in port enabled with PREFIX_ADDER_SEQ_CIN_EN.
module prefix_adder_seq
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef PREFIX_ADDER_SEQ_CIN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = levels_of(WIDTH);
  localparam int LW     = level_w(WIDTH);
  localparam logic [LW-1:0] LAST = LW'(LEVELS - 1);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("prefix_adder_seq: WIDTH must be a power of two >= 2");
  end

  state_e           state_q;
  state_e           state_d;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] g_n;
  logic [WIDTH-1:0] p_n;
  logic [WIDTH-1:0] g_init;
  logic [WIDTH-1:0] sum_d;
  logic             cin_q;
  logic             accept;
  logic             last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready & in_valid;
  assign last      = (state_q == ITER) && (level_q == LAST);

`ifdef PREFIX_ADDER_SEQ_CIN_EN
  always_ff @(posedge clk) begin
    if (rst)
      cin_q <= 1'b0;
    else if (accept)
      cin_q <= cin;
  end

  always_comb begin
    g_init    = a & b;
    g_init[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
  end
`else
  assign cin_q  = 1'b0;
  assign g_init = a & b;
`endif

  prefix_row #(
    .WIDTH(WIDTH),
    .LW   (LW)
  ) u_row (
    .level(level_q),
    .g_in (g_q),
    .p_in (p_q),
    .g_out(g_n),
    .p_out(p_n)
  );

  // Carry into bit i is the final group generate of bits below it.
  assign sum_d = x_q ^ {g_n[WIDTH-2:0], cin_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ITER;
      ITER:    if (level_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      g_q     <= '0;
      p_q     <= '0;
      x_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        level_q <= '0;
        g_q     <= g_init;
        p_q     <= a ^ b;
        x_q     <= a ^ b;
      end else if (state_q == ITER) begin
        g_q     <= g_n;
        p_q     <= p_n;
        level_q <= last ? '0 : level_q + 1'b1;
        if (last) begin
          sum  <= sum_d;
          cout <= g_n[WIDTH-1];
        end
      end
    end
  end

endmodule
